// File: rtl/fact_pkg.sv
// Shared types and defaults for the factorial compute engine.
package fact_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_RES_W  = 64;
    localparam int DEF_MAX_N  = 20;
    localparam int DEF_CNT_W  = 16;

    localparam logic [63:0] ONE = 64'd1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_WAIT = 3'd2,
        ST_MUL  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Classification of a freshly popped operand, decided in WAIT.
    typedef enum logic [1:0] {
        CLS_TRIV = 2'd0,
        CLS_MUL  = 2'd1,
        CLS_OVF  = 2'd2
    } op_class_t;

endpackage

// File: rtl/fact_core_ns.sv
// Next-state logic of the factorial engine controller.
module fact_core_ns
    import fact_pkg::*;
(
    input  logic [2:0] state,
    input  logic       fifo_empty,
    input  logic       fifo_rd_ack,
    input  logic [1:0] op_class,
    input  logic       cnt_is_two,
    input  logic       res_ready,
    output logic [2:0] next_state
);

    always_comb begin
        next_state = state;
        case (state_t'(state))
            ST_IDLE: if (!fifo_empty) next_state = ST_POP;
            ST_POP:  next_state = ST_WAIT;
            ST_WAIT: begin
                // A missing acknowledge is a read error: drop back and retry from IDLE.
                if (!fifo_rd_ack)
                    next_state = ST_IDLE;
                else if (op_class_t'(op_class) == CLS_MUL)
                    next_state = ST_MUL;
                else
                    next_state = ST_DONE;
            end
            ST_MUL:  if (cnt_is_two) next_state = ST_DONE;
            ST_DONE: if (res_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/fact_core.sv
// Factorial engine: pops N from the input FIFO, computes N! one multiply per
// cycle and hands the result off on a valid/ready interface.
module fact_core
    import fact_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RES_W  = DEF_RES_W,
    parameter int MAX_N  = DEF_MAX_N,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_rd_ack,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [RES_W-1:0]  res_data,
    output logic              res_ovf,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    logic [2:0]        state_reg, state_next;
    logic [RES_W-1:0]  acc_reg, acc_next;
    logic [DATA_W-1:0] cnt_reg, cnt_next;
    logic              ovf_reg, ovf_next;
    logic [CNT_W-1:0]  op_count_reg;
    logic [RES_W-1:0]  prod;
    logic [1:0]        op_class;
    logic              cnt_is_two;

    always_comb begin
        if (fifo_dout > DATA_W'(MAX_N))
            op_class = CLS_OVF;
        else if (fifo_dout <= DATA_W'(1))
            op_class = CLS_TRIV;
        else
            op_class = CLS_MUL;
    end

    assign cnt_is_two = (cnt_reg == DATA_W'(2));
    // Product is deliberately truncated to the result width every step.
    assign prod = acc_reg * {{(RES_W-DATA_W){1'b0}}, cnt_reg};

    fact_core_ns u_ns (
        .state       (state_reg),
        .fifo_empty  (fifo_empty),
        .fifo_rd_ack (fifo_rd_ack),
        .op_class    (op_class),
        .cnt_is_two  (cnt_is_two),
        .res_ready   (res_ready),
        .next_state  (state_next)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        acc_next = acc_reg;
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        case (state_t'(state_reg))
            ST_IDLE: begin
                if (state_next == ST_POP) begin
                    acc_next = '0;
                    ovf_next = 1'b0;
                end
            end
            ST_WAIT: begin
                if (fifo_rd_ack) begin
                    case (op_class_t'(op_class))
                        CLS_OVF: begin
                            acc_next = '0;
                            ovf_next = 1'b1;
                        end
                        CLS_TRIV: acc_next = RES_W'(ONE);
                        default: begin
                            acc_next = RES_W'(ONE);
                            cnt_next = fifo_dout;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                acc_next = prod;
                cnt_next = cnt_reg - DATA_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            op_count_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
            if (state_reg == ST_DONE && res_ready)
                op_count_reg <= op_count_reg + CNT_W'(1);
        end
    end

    always_comb begin
        fifo_rd_en = (state_reg == ST_POP);
        res_valid  = (state_reg == ST_DONE);
        busy       = (state_reg != ST_IDLE);
        res_data   = acc_reg;
        res_ovf    = ovf_reg;
        op_count   = op_count_reg;
    end

endmodule

// File: tb/tb_fact_core.sv
// Scoreboard bench for fact_core: FIFO model feeds operands, a reference
// factorial model predicts results, and a negedge monitor checks handoffs.
module tb_fact_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_dout;
    logic        fifo_rd_ack;
    logic        res_ready;
    logic        res_valid;
    logic [63:0] res_data;
    logic        res_ovf;
    logic        busy;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    fact_core dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_dout   (fifo_dout),
        .fifo_rd_ack (fifo_rd_ack),
        .res_ready   (res_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ovf     (res_ovf),
        .busy        (busy),
        .op_count    (op_count)
    );

    typedef struct {
        logic [63:0] data;
        logic        ovf;
        int          lat;
        int unsigned n;
    } exp_t;

    exp_t        exp_q[$];
    int          wait_q[$];
    int unsigned fifo_q[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] exp_ops = '0;
    int          err_req = 0;
    int          err_done = 0;

    function automatic exp_t ref_model(int unsigned n);
        exp_t e;
        longint unsigned f = 1;
        e.n = n;
        if (n > 20) begin
            e.data = 64'd0;
            e.ovf  = 1'b1;
            e.lat  = 1;
        end else begin
            for (int unsigned k = 2; k <= n; k++) f = f * longint'(k);
            e.data = f;
            e.ovf  = 1'b0;
            e.lat  = (n >= 2) ? int'(n) : 1;
        end
        return e;
    endfunction

    assign fifo_empty = (fifo_q.size() == 0);

    // Input FIFO with registered read; an injected error withholds rd_ack.
    always @(posedge clk) begin
        if (reset) begin
            fifo_rd_ack <= 1'b0;
            fifo_dout   <= '0;
        end else if (fifo_rd_en) begin
            if (err_req != err_done) begin
                err_done    <= err_done + 1;
                fifo_rd_ack <= 1'b0;
                fifo_dout   <= $urandom;
            end else if (fifo_q.size() > 0) begin
                fifo_dout   <= fifo_q[0];
                exp_q.push_back(ref_model(fifo_q[0]));
                void'(fifo_q.pop_front());
                fifo_rd_ack <= 1'b1;
            end else begin
                fifo_rd_ack <= 1'b0;
            end
        end else begin
            fifo_rd_ack <= 1'b0;
        end
    end

    int          ncyc = 0;
    logic        prev_valid = 1'b0;
    logic        rst_prev = 1'b0;
    logic        hold_active = 1'b0;
    logic [63:0] hold_data;
    logic        hold_ovf;

    always @(negedge clk) begin
        ncyc++;
        if (rst_prev) begin
            vectors++;
            if (res_valid || res_data != 64'd0 || res_ovf || busy || fifo_rd_en || op_count != 16'd0) begin
                errors++;
                $display("FAIL reset_state: valid=%0b data=%h ovf=%0b busy=%0b rd_en=%0b op_count=%0d, required all zero",
                         res_valid, res_data, res_ovf, busy, fifo_rd_en, op_count);
            end
            exp_q.delete();
            wait_q.delete();
            exp_ops     = '0;
            hold_active = 1'b0;
        end else begin
            if (fifo_rd_ack) wait_q.push_back(ncyc);
            if (res_valid && !prev_valid) begin
                vectors++;
                if (exp_q.size() == 0 || wait_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: res_valid=1 with no operand outstanding");
                end else begin
                    int w;
                    w = wait_q.pop_front();
                    if (ncyc - w != exp_q[0].lat) begin
                        errors++;
                        $display("FAIL latency N=%0d: got WAIT+%0d, required WAIT+%0d", exp_q[0].n, ncyc - w, exp_q[0].lat);
                    end
                end
            end
            if (res_valid && hold_active) begin
                vectors++;
                if (res_data != hold_data || res_ovf != hold_ovf || fifo_rd_en) begin
                    errors++;
                    $display("FAIL hold_stable: data=%h ovf=%0b rd_en=%0b, required data=%h ovf=%0b rd_en=0",
                             res_data, res_ovf, fifo_rd_en, hold_data, hold_ovf);
                end
            end
            if (res_valid && res_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL handoff: result %h with empty scoreboard", res_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (res_data != e.data || res_ovf != e.ovf || op_count != exp_ops) begin
                        errors++;
                        $display("FAIL result N=%0d: data=%h ovf=%0b op_count=%0d, required data=%h ovf=%0b op_count=%0d",
                                 e.n, res_data, res_ovf, op_count, e.data, e.ovf, exp_ops);
                    end else begin
                        $display("N=%0d -> %h ovf=%0b op_count=%0d", e.n, res_data, res_ovf, op_count);
                    end
                    exp_ops = exp_ops + 16'd1;
                end
                hold_active = 1'b0;
            end else if (res_valid) begin
                hold_active = 1'b1;
                hold_data   = res_data;
                hold_ovf    = res_ovf;
            end else begin
                hold_active = 1'b0;
            end
        end
        prev_valid = res_valid;
        rst_prev   = reset;
    end

    task automatic push(input int unsigned n);
        fifo_q.push_back(n);
    endtask

    // Run until everything queued has been handed off; optionally jitter res_ready.
    task automatic wait_idle(input bit rand_ready);
        int b = 0;
        @(posedge clk);
        #1;
        while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !busy) && b < 3000) begin
            if (rand_ready) res_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            b++;
        end
        res_ready = 1'b1;
        if (b >= 3000) begin
            vectors++;
            errors++;
            $display("FAIL timeout: pipeline did not drain, fifo=%0d pending=%0d busy=%0b",
                     fifo_q.size(), exp_q.size(), busy);
        end
    endtask

    initial begin
        int b;
        reset     = 1'b1;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        push(5);
        wait_idle(1'b0);
        push(0);
        push(1);
        wait_idle(1'b0);
        push(20);
        push(21);
        wait_idle(1'b0);

        // Back-pressure: hold the first result for 10 cycles.
        res_ready = 1'b0;
        push(3);
        push(4);
        push(6);
        b = 0;
        while (!res_valid && b < 200) begin
            @(posedge clk);
            #1;
            b++;
        end
        repeat (10) @(posedge clk);
        #1 res_ready = 1'b1;
        wait_idle(1'b0);

        // Read error on the first pop attempt.
        err_req++;
        push(7);
        wait_idle(1'b0);

        // Reset in the middle of computing 10!.
        push(10);
        b = 0;
        while (!fifo_rd_ack && b < 200) begin
            @(posedge clk);
            #1;
            b++;
        end
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        push(4);
        wait_idle(1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) err_req++;
            push($urandom_range(0, 25));
            if ($urandom_range(0, 1) == 1) push($urandom_range(0, 25));
            wait_idle(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
